// File: rtl/spi_master.sv
// spi_master: SPI mode-0 initiator (CPOL=0, CPHA=0, MSB first).
//
// Generates sclk by dividing clk, drives cs_n/mosi and captures miso. A
// start/busy/done handshake moves single words or bursts; cs_n stays low
// between the words of a burst until a word flagged with `last` finishes.
//
// Ports
//   clk    in   system clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   start  in   request one word (accepted only while busy=0)
//   last   in   sampled with start; release cs_n after this word
//   din    in   WIDTH-bit word to send, sampled with start
//   busy   out  transfer in progress
//   done   out  one-cycle pulse, dout valid in the same cycle
//   dout   out  last received word, held until the next done
//   sclk   out  SPI clock, idles low
//   cs_n   out  chip select, active low
//   mosi   out  serial data to slave
//   miso   in   serial data from slave
module spi_master #(
  parameter int WIDTH   = 8,
  parameter int CLK_DIV = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             last,
  input  logic [WIDTH-1:0] din,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] dout,
  output logic             sclk,
  output logic             cs_n,
  output logic             mosi,
  input  logic             miso
);

  localparam int DW = $clog2(CLK_DIV + 1);
  localparam int BW = $clog2(WIDTH + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_HIGH,
    S_LOW,
    S_WAIT,
    S_TAIL
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [DW-1:0]    div_cnt;
  logic [BW-1:0]    bit_cnt;
  logic             last_q;
  logic [WIDTH-1:0] tx_sr;
  logic [WIDTH-1:0] rx_sr;

  logic tick;
  logic accept;
  logic rise;
  logic fall;
  logic word_end;
  logic tail_end;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_WAIT: if (accept) state_d = S_SETUP;
      S_SETUP, S_LOW: if (rise) state_d = S_HIGH;
      S_HIGH: begin
        if (word_end)  state_d = last_q ? S_TAIL : S_WAIT;
        else if (fall) state_d = S_LOW;
      end
      S_TAIL:         if (tail_end) state_d = S_IDLE;
      default:        state_d = S_IDLE;
    endcase
  end

  // Event decode: each timed state ends when the divider reaches CLK_DIV-1
  always_comb begin
    tick     = (div_cnt == DIV_LAST);
    accept   = 1'b0;
    rise     = 1'b0;
    fall     = 1'b0;
    word_end = 1'b0;
    tail_end = 1'b0;
    case (state_q)
      S_IDLE, S_WAIT: accept = start;
      S_SETUP, S_LOW: rise = tick;
      S_HIGH: begin
        fall     = tick;
        word_end = tick && (bit_cnt == BIT_LAST);
      end
      S_TAIL:         tail_end = tick;
      default:        ;
    endcase
  end

  // Control and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      bit_cnt <= '0;
      last_q  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      dout    <= '0;
      sclk    <= 1'b0;
      cs_n    <= 1'b1;
      mosi    <= 1'b0;
    end else begin
      done <= word_end;

      // Divider runs only in the timed states; every tick changes state,
      // so clearing on tick restarts it for the next phase.
      if ((state_q inside {S_SETUP, S_HIGH, S_LOW, S_TAIL}) && !tick)
        div_cnt <= div_cnt + 1'b1;
      else
        div_cnt <= '0;

      if (accept) begin
        busy    <= 1'b1;
        cs_n    <= 1'b0;
        mosi    <= din[WIDTH-1];
        last_q  <= last;
        bit_cnt <= '0;
      end

      if (rise) sclk <= 1'b1;

      if (fall) begin
        sclk <= 1'b0;
        if (word_end) begin
          dout <= rx_sr;
          // A non-final burst word frees the handshake while cs_n stays low
          if (!last_q) busy <= 1'b0;
        end else begin
          mosi    <= tx_sr[WIDTH-2];
          bit_cnt <= bit_cnt + 1'b1;
        end
      end

      if (tail_end) begin
        cs_n <= 1'b1;
        busy <= 1'b0;
        mosi <= 1'b0;
      end
    end
  end

  // Shift registers (data only, fully reloaded/refilled every word)
  always_ff @(posedge clk) begin
    if (accept)
      tx_sr <= din;
    else if (fall && !word_end)
      // Rotate so the current bit always sits at the MSB
      tx_sr <= {tx_sr[WIDTH-2:0], tx_sr[WIDTH-1]};

    // miso is captured on the same clk edge that raises sclk
    if (rise)
      rx_sr <= {rx_sr[WIDTH-2:0], miso};
  end

endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: directed bench for spi_master. Instance u0 uses CLK_DIV=2
// with a mode-0 slave model; instance u1 uses CLK_DIV=1 with miso tied high.
module tb_spi_master;

  localparam logic [7:0] SLV_PRE = 8'hA5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       start0 = 1'b0, last0 = 1'b0;
  logic [7:0] din0 = 8'h00;
  logic       busy0, done0, sclk0, cs0, mosi0, miso0;
  logic [7:0] dout0;

  logic       start1 = 1'b0, last1 = 1'b0;
  logic [7:0] din1 = 8'h00;
  logic       busy1, done1, sclk1, cs1, mosi1;
  logic [7:0] dout1;

  int total = 0;
  int bad = 0;

  spi_master #(.WIDTH(8), .CLK_DIV(2)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .last(last0), .din(din0),
    .busy(busy0), .done(done0), .dout(dout0), .sclk(sclk0), .cs_n(cs0),
    .mosi(mosi0), .miso(miso0)
  );

  spi_master #(.WIDTH(8), .CLK_DIV(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .last(last1), .din(din1),
    .busy(busy1), .done(done1), .dout(dout1), .sclk(sclk1), .cs_n(cs1),
    .mosi(mosi1), .miso(1'b1)
  );

  // Oversampled mode-0 slave for u0: samples mosi on sclk rise, shifts
  // miso after sclk fall, reloads SLV_PRE at cs_n fall and after 8 bits.
  logic       sclk_q = 1'b0, csn_q = 1'b1;
  logic [7:0] tx_s = 8'h00;
  logic [6:0] rx_s = 7'h00;
  logic [7:0] s_word = 8'h00;
  int         s_bit = 0;
  int         s_rises = 0;
  assign miso0 = tx_s[7];

  always @(posedge clk) begin
    sclk_q <= sclk0;
    csn_q  <= cs0;
    if (!cs0 && csn_q) begin
      tx_s  <= SLV_PRE;
      s_bit <= 0;
    end else if (!cs0 && sclk0 && !sclk_q) begin
      rx_s    <= {rx_s[5:0], mosi0};
      s_rises <= s_rises + 1;
      s_bit   <= s_bit + 1;
      if (s_bit == 7) s_word <= {rx_s, mosi0};
    end else if (!cs0 && !sclk0 && sclk_q) begin
      if (s_bit == 8) begin
        tx_s  <= SLV_PRE;
        s_bit <= 0;
      end else begin
        tx_s <= {tx_s[6:0], 1'b0};
      end
    end
  end

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (cs0 !== 1'b1) begin bad++; $display("FAIL reset_cs_n: got %b want 1", cs0); end
    total++; if (sclk0 !== 1'b0) begin bad++; $display("FAIL reset_sclk: got %b want 0", sclk0); end
    total++; if (mosi0 !== 1'b0) begin bad++; $display("FAIL reset_mosi: got %b want 0", mosi0); end
    total++; if (busy0 !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy0); end
    total++; if (done0 !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done0); end
    total++; if (dout0 !== 8'h00) begin bad++; $display("FAIL reset_dout: got %h want 00", dout0); end
    total++; if (cs1 !== 1'b1 || sclk1 !== 1'b0) begin bad++; $display("FAIL reset_u1: got cs_n=%b sclk=%b want 1 0", cs1, sclk1); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single;
    int de = -1, ce = -1, nd = 0, r0;
    logic b33 = 1'b0, b34 = 1'b1;
    r0 = s_rises;
    din0 = 8'h3C; last0 = 1'b1; start0 = 1'b1;
    for (int n = 0; n <= 45; n++) begin
      @(negedge clk);
      if (n == 0) begin
        start0 = 1'b0;
        total++; if (cs0 !== 1'b0 || busy0 !== 1'b1 || mosi0 !== 1'b0) begin
          bad++; $display("FAIL single_edge0: got cs_n=%b busy=%b mosi=%b want 0 1 0", cs0, busy0, mosi0);
        end
      end
      if (done0) begin
        nd++;
        if (de < 0) de = n;
        total++; if (dout0 !== SLV_PRE) begin bad++; $display("FAIL single_dout: got %h want a5", dout0); end
      end
      if (cs0 && ce < 0) ce = n;
      if (n == 33) b33 = busy0;
      if (n == 34) b34 = busy0;
    end
    total++; if (de !== 32) begin bad++; $display("FAIL single_done_edge: got %0d want 32", de); end
    total++; if (nd !== 1) begin bad++; $display("FAIL single_done_count: got %0d want 1", nd); end
    total++; if (ce !== 34) begin bad++; $display("FAIL single_cs_edge: got %0d want 34", ce); end
    total++; if (b33 !== 1'b1 || b34 !== 1'b0) begin bad++; $display("FAIL single_busy_fall: got %b%b want 10", b33, b34); end
    total++; if (s_rises - r0 !== 8) begin bad++; $display("FAIL single_sclk_rises: got %0d want 8", s_rises - r0); end
    total++; if (s_word !== 8'h3C) begin bad++; $display("FAIL single_slave_rx: got %h want 3c", s_word); end
  endtask

  task automatic test_burst;
    logic [7:0] w [4] = '{8'h3C, 8'h80, 8'h36, 8'h1B};
    int nd = 0, cs_rose = 0, r0, de;
    r0 = s_rises;
    din0 = w[0]; last0 = 1'b0; start0 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      de = -1;
      for (int n = 0; n <= 60; n++) begin
        @(negedge clk);
        if (n == 0) start0 = 1'b0;
        if (cs0) cs_rose++;
        if (done0) begin de = n; nd++; break; end
      end
      total++; if (de !== 32) begin bad++; $display("FAIL burst_done_edge%0d: got %0d want 32", i, de); end
      total++; if (dout0 !== SLV_PRE) begin bad++; $display("FAIL burst_dout%0d: got %h want a5", i, dout0); end
      if (i < 3) begin
        total++; if (busy0 !== 1'b0 || cs0 !== 1'b0 || mosi0 !== w[i][0]) begin
          bad++; $display("FAIL burst_wait%0d: got busy=%b cs_n=%b mosi=%b want 0 0 %b", i, busy0, cs0, mosi0, w[i][0]);
        end
        din0 = w[i+1]; last0 = (i == 2); start0 = 1'b1;
      end
    end
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (cs0) break;
    end
    total++; if (cs0 !== 1'b1) begin bad++; $display("FAIL burst_cs_end: got %b want 1", cs0); end
    total++; if (nd !== 4) begin bad++; $display("FAIL burst_done_count: got %0d want 4", nd); end
    total++; if (cs_rose !== 0) begin bad++; $display("FAIL burst_cs_gap: got %0d high cycles want 0", cs_rose); end
    total++; if (s_rises - r0 !== 32) begin bad++; $display("FAIL burst_sclk_rises: got %0d want 32", s_rises - r0); end
    total++; if (s_word !== 8'h1B) begin bad++; $display("FAIL burst_slave_rx: got %h want 1b", s_word); end
    last0 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_ignore;
    int de = -1, ce = -1, drops = 0;
    din0 = 8'h3C; last0 = 1'b1; start0 = 1'b1;
    for (int n = 0; n <= 40; n++) begin
      @(negedge clk);
      start0 = 1'b0; din0 = 8'h3C; last0 = 1'b1;
      if (n == 4 || n == 19) begin start0 = 1'b1; din0 = 8'hFF; last0 = 1'b0; end
      if (n >= 1 && n <= 33 && busy0 !== 1'b1) drops++;
      if (done0 && de < 0) de = n;
      if (cs0 && ce < 0) ce = n;
    end
    total++; if (drops !== 0) begin bad++; $display("FAIL ignore_busy: got %0d low cycles want 0", drops); end
    total++; if (de !== 32) begin bad++; $display("FAIL ignore_done_edge: got %0d want 32", de); end
    total++; if (ce !== 34) begin bad++; $display("FAIL ignore_cs_edge: got %0d want 34", ce); end
    total++; if (s_word !== 8'h3C) begin bad++; $display("FAIL ignore_slave_rx: got %h want 3c", s_word); end
  endtask

  task automatic test_reset_mid;
    int dn = 0, de = -1;
    din0 = 8'h3C; last0 = 1'b1; start0 = 1'b1;
    for (int n = 0; n <= 9; n++) begin
      @(negedge clk);
      start0 = 1'b0;
    end
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    total++; if (cs0 !== 1'b1 || sclk0 !== 1'b0 || busy0 !== 1'b0 || mosi0 !== 1'b0) begin
      bad++; $display("FAIL abort_outputs: got cs_n=%b sclk=%b busy=%b mosi=%b want 1 0 0 0", cs0, sclk0, busy0, mosi0);
    end
    repeat (3) begin @(negedge clk); if (done0) dn++; end
    rst_n = 1'b1;
    repeat (40) begin @(negedge clk); if (done0) dn++; end
    total++; if (dn !== 0) begin bad++; $display("FAIL abort_no_done: got %0d want 0", dn); end
    din0 = 8'h3C; last0 = 1'b1; start0 = 1'b1;
    for (int n = 0; n <= 40; n++) begin
      @(negedge clk);
      start0 = 1'b0;
      if (done0 && de < 0) de = n;
    end
    total++; if (de !== 32) begin bad++; $display("FAIL after_abort_done_edge: got %0d want 32", de); end
    total++; if (dout0 !== SLV_PRE) begin bad++; $display("FAIL after_abort_dout: got %h want a5", dout0); end
    total++; if (s_word !== 8'h3C) begin bad++; $display("FAIL after_abort_slave_rx: got %h want 3c", s_word); end
  endtask

  task automatic test_div1;
    logic [7:0] dv = 8'h81;
    logic exp_s;
    int de = -1, ce = -1;
    din1 = dv; last1 = 1'b1; start1 = 1'b1;
    for (int n = 0; n <= 22; n++) begin
      @(negedge clk);
      if (n == 0) begin
        start1 = 1'b0;
        total++; if (cs1 !== 1'b0 || busy1 !== 1'b1 || mosi1 !== 1'b1) begin
          bad++; $display("FAIL div1_edge0: got cs_n=%b busy=%b mosi=%b want 0 1 1", cs1, busy1, mosi1);
        end
      end
      if (n >= 1 && n <= 16) begin
        exp_s = (n % 2 == 1);
        total++; if (sclk1 !== exp_s) begin bad++; $display("FAIL div1_sclk_e%0d: got %b want %b", n, sclk1, exp_s); end
        if (exp_s) begin
          total++; if (mosi1 !== dv[7 - (n - 1) / 2]) begin
            bad++; $display("FAIL div1_mosi_e%0d: got %b want %b", n, mosi1, dv[7 - (n - 1) / 2]);
          end
        end
      end
      if (done1 && de < 0) de = n;
      if (cs1 && ce < 0) ce = n;
    end
    total++; if (de !== 16) begin bad++; $display("FAIL div1_done_edge: got %0d want 16", de); end
    total++; if (ce !== 17) begin bad++; $display("FAIL div1_cs_edge: got %0d want 17", ce); end
    total++; if (dout1 !== 8'hFF) begin bad++; $display("FAIL div1_dout: got %h want ff", dout1); end
    total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL div1_busy_end: got %b want 0", busy1); end
  endtask

  task automatic test_back_to_back;
    int d1 = -1, d2 = -1, ce = -1;
    logic cs34 = 1'b0, cs35 = 1'b1, b35 = 1'b0;
    din0 = 8'h3C; last0 = 1'b1; start0 = 1'b1;
    for (int n = 0; n <= 68; n++) begin
      @(negedge clk);
      if (done0) begin
        if (d1 < 0) d1 = n;
        else if (d2 < 0) d2 = n;
      end
      if (cs0 && ce < 0) ce = n;
      if (n == 34) cs34 = cs0;
      if (n == 35) begin cs35 = cs0; b35 = busy0; end
    end
    start0 = 1'b0;
    repeat (4) @(negedge clk);
    total++; if (d1 !== 32) begin bad++; $display("FAIL b2b_done1_edge: got %0d want 32", d1); end
    total++; if (d2 !== 67) begin bad++; $display("FAIL b2b_done2_edge: got %0d want 67", d2); end
    total++; if (ce !== 34) begin bad++; $display("FAIL b2b_cs_edge: got %0d want 34", ce); end
    total++; if (cs34 !== 1'b1 || cs35 !== 1'b0 || b35 !== 1'b1) begin
      bad++; $display("FAIL b2b_gap: got cs34=%b cs35=%b busy35=%b want 1 0 1", cs34, cs35, b35);
    end
    total++; if (cs0 !== 1'b1 || busy0 !== 1'b0) begin
      bad++; $display("FAIL b2b_idle_end: got cs_n=%b busy=%b want 1 0", cs0, busy0);
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_burst;
    test_ignore;
    test_reset_mid;
    test_div1;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
